// File: rtl/uart_stream_bridge.sv
// 8N1 UART bridge with small RX/TX FIFOs, valid/ready streams and sticky error flags.
// Define UART_LOOPBACK_EN to add a loopback port that routes the TX line back into the receiver.
module uart_stream_bridge #(
    parameter int CLK_HZ   = 10_000_000,
    parameter int BAUD     = 9600,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4
) (
    input  logic       clk_10M,
    input  logic       reset_btn,
    input  logic       rxd,
    output logic       txd,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic       rx_overrun,
    output logic       frame_err,
    output logic       tx_busy
`ifdef UART_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int TXAW = $clog2(TX_DEPTH);

    localparam logic [CW-1:0]   DIV_M1      = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF_M1     = CW'(HALF - 1);
    localparam logic [RXAW:0]   RX_FULL_CNT = (RXAW + 1)'(RX_DEPTH);
    localparam logic [TXAW:0]   TX_FULL_CNT = (TXAW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic r_txd;
    logic w_rx_in;
    logic r_rx_meta;
    logic r_rxs;

`ifdef UART_LOOPBACK_EN
    assign w_rx_in = loopback ? r_txd : rxd;
    assign txd     = loopback ? 1'b1 : r_txd;
`else
    assign w_rx_in = rxd;
    assign txd     = r_txd;
`endif

    always_ff @(posedge clk_10M or posedge reset_btn) begin
        if (reset_btn) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= w_rx_in;
            r_rxs     <= r_rx_meta;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]      r_rx_mem [RX_DEPTH];
    logic [RXAW-1:0] r_rx_wptr;
    logic [RXAW-1:0] r_rx_rptr;
    logic [RXAW:0]   r_rx_count;
    logic            w_rx_push;
    logic            w_rx_pop;
    logic            w_rx_full;
    logic [7:0]      r_rx_shift;

    assign rx_valid  = (r_rx_count != '0);
    assign w_rx_pop  = rx_valid && rx_ready;
    // A pop in the same cycle makes room for the byte being pushed.
    assign w_rx_full = (r_rx_count == RX_FULL_CNT) && !w_rx_pop;
    assign rx_data   = rx_valid ? r_rx_mem[r_rx_rptr] : 8'h00;

    always_ff @(posedge clk_10M) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk_10M or posedge reset_btn) begin
        if (reset_btn) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t     r_rx_state, w_rx_state_next;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_next;
    logic [2:0]    r_rx_bits, w_rx_bits_next;
    logic [7:0]    w_rx_shift_next;
    logic          w_set_overrun;
    logic          w_set_frame;

    always_ff @(posedge clk_10M or posedge reset_btn) begin
        if (reset_btn) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bits  <= w_rx_bits_next;
            r_rx_shift <= w_rx_shift_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_bits_next  = r_rx_bits;
        w_rx_shift_next = r_rx_shift;
        w_rx_push       = 1'b0;
        w_set_overrun   = 1'b0;
        w_set_frame     = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rxs) begin
                    w_rx_state_next = RX_START;
                    w_rx_cnt_next   = '0;
                end
            end
            RX_START: begin
                // Re-check the line mid start bit so short glitches are ignored.
                if (r_rx_cnt == HALF_M1) begin
                    w_rx_cnt_next   = '0;
                    w_rx_bits_next  = '0;
                    w_rx_state_next = r_rxs ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == DIV_M1) begin
                    w_rx_cnt_next   = '0;
                    w_rx_shift_next = {r_rxs, r_rx_shift[7:1]};
                    w_rx_bits_next  = r_rx_bits + 1'b1;
                    if (r_rx_bits == 3'd7) w_rx_state_next = RX_STOP;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == DIV_M1) begin
                    w_rx_cnt_next   = '0;
                    w_rx_state_next = RX_IDLE;
                    if (!r_rxs)         w_set_frame   = 1'b1;
                    else if (w_rx_full) w_set_overrun = 1'b1;
                    else                w_rx_push     = 1'b1;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_next = RX_IDLE;
        endcase
    end

    // Sticky flags: a set in the same cycle as err_clr wins.
    always_ff @(posedge clk_10M or posedge reset_btn) begin
        if (reset_btn) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (w_set_overrun)  rx_overrun <= 1'b1;
            else if (err_clr)   rx_overrun <= 1'b0;
            if (w_set_frame)    frame_err  <= 1'b1;
            else if (err_clr)   frame_err  <= 1'b0;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]      r_tx_mem [TX_DEPTH];
    logic [TXAW-1:0] r_tx_wptr;
    logic [TXAW-1:0] r_tx_rptr;
    logic [TXAW:0]   r_tx_count;
    logic            w_tx_push;
    logic            w_tx_pop;
    logic            w_tx_nonempty;

    assign tx_ready      = (r_tx_count != TX_FULL_CNT);
    assign w_tx_push     = tx_valid && tx_ready;
    assign w_tx_nonempty = (r_tx_count != '0);

    always_ff @(posedge clk_10M) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= tx_data;
        end
    end

    always_ff @(posedge clk_10M or posedge reset_btn) begin
        if (reset_btn) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t     r_tx_state, w_tx_state_next;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_next;
    logic [2:0]    r_tx_bits, w_tx_bits_next;
    logic [7:0]    r_tx_shift, w_tx_shift_next;
    logic          w_txd_next;

    assign tx_busy = (r_tx_state != TX_IDLE) || w_tx_nonempty;

    always_ff @(posedge clk_10M or posedge reset_btn) begin
        if (reset_btn) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bits  <= w_tx_bits_next;
            r_tx_shift <= w_tx_shift_next;
            r_txd      <= w_txd_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_bits_next  = r_tx_bits;
        w_tx_shift_next = r_tx_shift;
        w_txd_next      = r_txd;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_txd_next = 1'b1;
                if (w_tx_nonempty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = r_tx_mem[r_tx_rptr];
                    w_txd_next      = 1'b0;
                    w_tx_cnt_next   = '0;
                    w_tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == DIV_M1) begin
                    w_tx_cnt_next   = '0;
                    w_tx_bits_next  = '0;
                    w_txd_next      = r_tx_shift[0];
                    w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                    w_tx_state_next = TX_DATA;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == DIV_M1) begin
                    w_tx_cnt_next = '0;
                    if (r_tx_bits == 3'd7) begin
                        w_txd_next      = 1'b1;
                        w_tx_state_next = TX_STOP;
                    end else begin
                        w_txd_next      = r_tx_shift[0];
                        w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                        w_tx_bits_next  = r_tx_bits + 1'b1;
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == DIV_M1) begin
                    w_tx_cnt_next   = '0;
                    w_tx_state_next = TX_IDLE;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_state_next = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge at 96000 baud (104 clocks/bit) to keep the run short.
`timescale 1ns/1ps
module tb_uart_stream_bridge;

    localparam int DIV  = 104;  // 10 MHz / 96000, truncated
    localparam int HALF = 52;

    logic       clk_10M   = 1'b0;
    logic       reset_btn = 1'b1;
    logic       rxd       = 1'b1;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       rx_ready  = 1'b0;
    logic       err_clr   = 1'b0;
    logic       txd;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       frame_err;
    logic       tx_busy;

    int vectors     = 0;
    int miscompares = 0;

    always #50 clk_10M = ~clk_10M;

    uart_stream_bridge #(
        .CLK_HZ   (10_000_000),
        .BAUD     (96_000),
        .RX_DEPTH (4),
        .TX_DEPTH (4)
    ) dut (
        .clk_10M    (clk_10M),
        .reset_btn  (reset_btn),
        .rxd        (rxd),
        .txd        (txd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .err_clr    (err_clr),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .tx_busy    (tx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=0x%0h exp=0x%0h", vectors, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_10M);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Start bit plus 8 data bits; leaves the line on the last data bit.
    task automatic send_bits(input logic [7:0] d);
        rxd = 1'b0;
        ticks(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            ticks(DIV);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        send_bits(d);
        rxd = stop_bit;
        ticks(DIV);
        rxd = 1'b1;
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic push_tx(input string tag, input logic [7:0] d);
        int n;
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 20 * DIV) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_start(output int gap);
        gap = 0;
        while (txd !== 1'b0 && gap < 4 * DIV) begin
            tick();
            gap++;
        end
    endtask

    // Called on the first cycle txd is low; walks all ten bit periods.
    task automatic check_frame(input string tag, input logic [7:0] d, output logic busy_last);
        logic [9:0] exp_w;
        logic [9:0] obs_w;
        int bad;
        exp_w = {1'b1, d, 1'b0};
        obs_w = '0;
        bad = 0;
        busy_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < DIV; j++) begin
                if (j == HALF) obs_w[i] = txd;
                if (txd !== exp_w[i]) bad++;
                if (i == 9 && j == DIV - 1) busy_last = tx_busy;
                tick();
            end
        end
        chk({tag, "_bits"}, {22'd0, obs_w}, {22'd0, exp_w});
        chk({tag, "_held"}, bad, 32'd0);
    endtask

    logic [7:0] bp_bytes [6] = '{8'hC3, 8'h5A, 8'h0F, 8'hF0, 8'h99, 8'h66};

    initial begin
        int n;
        int gap;
        logic busy_last;

        // Reset state
        ticks(3);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        reset_btn = 1'b0;
        ticks(2);

        // TX 0x55 on an idle line
        push_tx("tx55", 8'h55);
        chk("tx55_pre_start", {31'd0, txd}, 32'd1);
        chk("tx55_busy", {31'd0, tx_busy}, 32'd1);
        tick();
        chk("tx55_start", {31'd0, txd}, 32'd0);
        check_frame("tx55", 8'h55, busy_last);
        chk("tx55_busy_in_stop", {31'd0, busy_last}, 32'd1);
        chk("tx55_busy_after", {31'd0, tx_busy}, 32'd0);
        chk("tx55_idle", {31'd0, txd}, 32'd1);

        // RX 0xA5 with latency measured from the stop bit start
        send_bits(8'hA5);
        rxd = 1'b1;
        n = 0;
        while (rx_valid !== 1'b1 && n < 2 * DIV) begin
            tick();
            n++;
        end
        chk("rxa5_latency", n, HALF + 3);
        ticks(DIV - n);
        pop_rx("rxa5", 8'hA5);
        chk("rxa5_empty", {31'd0, rx_valid}, 32'd0);
        chk("rxa5_no_ferr", {31'd0, frame_err}, 32'd0);

        // Overrun: five bytes into a four-entry FIFO
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
        chk("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        pop_rx("ovr_b1", 8'h01);
        pop_rx("ovr_b2", 8'h02);
        pop_rx("ovr_b3", 8'h03);
        pop_rx("ovr_b4", 8'h04);
        chk("ovr_drained", {31'd0, rx_valid}, 32'd0);
        chk("ovr_still_set", {31'd0, rx_overrun}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovr_cleared", {31'd0, rx_overrun}, 32'd0);

        // Framing error on 0x3C, then a good 0x7E
        send_byte(8'h3C, 1'b0);
        chk("ferr_flag", {31'd0, frame_err}, 32'd1);
        chk("ferr_no_byte", {31'd0, rx_valid}, 32'd0);
        ticks(2 * DIV);
        chk("ferr_idle_no_byte", {31'd0, rx_valid}, 32'd0);
        send_byte(8'h7E, 1'b1);
        pop_rx("ferr_next", 8'h7E);
        chk("ferr_sticky", {31'd0, frame_err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ferr_cleared", {31'd0, frame_err}, 32'd0);

        // Short low glitch must be ignored
        rxd = 1'b0;
        ticks(30);
        rxd = 1'b1;
        ticks(2 * DIV);
        chk("glitch_no_byte", {31'd0, rx_valid}, 32'd0);
        chk("glitch_no_ferr", {31'd0, frame_err}, 32'd0);
        chk("glitch_no_ovr", {31'd0, rx_overrun}, 32'd0);

        // TX backpressure: six bytes, back-to-back frames
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    push_tx("bp_push", bp_bytes[k]);
                    if (k == 4) chk("bp_full_ready", {31'd0, tx_ready}, 32'd0);
                end
            end
            begin
                logic bl;
                int g;
                for (int k = 0; k < 6; k++) begin
                    wait_tx_start(g);
                    if (k > 0) chk("bp_gap", g, 32'd1);
                    check_frame("bp_frame", bp_bytes[k], bl);
                end
            end
        join
        chk("bp_busy_after", {31'd0, tx_busy}, 32'd0);

        // Reset mid-frame, then a fresh 0x80
        push_tx("rst_push", 8'h00);
        ticks(3 * DIV);
        chk("pre_rst_txd", {31'd0, txd}, 32'd0);
        #20 reset_btn = 1'b1;
        #1;
        chk("rst_async_txd", {31'd0, txd}, 32'd1);
        chk("rst_async_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_async_busy", {31'd0, tx_busy}, 32'd0);
        ticks(3);
        reset_btn = 1'b0;
        tick();
        chk("post_rst_txd", {31'd0, txd}, 32'd1);
        push_tx("tx80", 8'h80);
        wait_tx_start(gap);
        chk("tx80_latency", gap, 32'd1);
        check_frame("tx80", 8'h80, busy_last);
        chk("tx80_busy_after", {31'd0, tx_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
